prod_acc: RTL and testbench



---
 rtl/prod_acc.sv | 149 ++++++++++++++
 tb/tb_prod_acc.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prod_acc.sv
//------------------------------------------------------------------------------
// prod_acc
//
// Signed product accumulator for the 4x4 signed multiplier. After an accepted
// start it sums a programmed number of 8-bit two's-complement products (one
// per in_valid/in_ready transfer) into an ACC_W-bit signed accumulator. The
// total is then offered on a valid/ready result handshake.
//
// Build option:
//   PROD_ACC_SAT_EN  defined   -> acc saturates to the ACC_W signed limits
//                               when a sum goes out of range
//                    undefined -> acc wraps modulo 2^ACC_W
//   In both builds ovf is a sticky out-of-range flag that is cleared by the
//   next accepted start.
//
// Parameters:
//   ACC_W      accumulator width in bits, two's complement. Legal range 8..16.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      begin a new accumulation; sampled only in IDLE
//   n_terms    number of products to accumulate (0..15); latched on start
//   in_valid   prod is valid this cycle
//   prod       signed 8-bit product
//   in_ready   block accepts prod this cycle (state decode)
//   acc        running/final signed sum
//   ovf        sticky overflow flag for the current accumulation
//   busy       high in ACC or DONE
//   out_valid  acc holds the final result (state decode)
//   out_ready  consumer takes the result
//------------------------------------------------------------------------------
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; acc/ovf keep the last result
// ACC   | in_ready=1, summing one product per transfer, counting down
// DONE  | out_valid=1, acc frozen until out_ready
//------------------------------------------------------------------------------
module prod_acc #(
  parameter int ACC_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       n_terms,
  input  logic             in_valid,
  input  logic [7:0]       prod,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W:0]   sum_ext;
  logic             sum_ovf;
  logic [ACC_W-1:0] sum_wr;
  logic             last_term;

  // One guard bit above the accumulator: the sum of an in-range ACC_W value
  // and an 8-bit product always fits in ACC_W+1 bits, so a disagreement
  // between the two top bits is exactly the out-of-range condition.
  assign sum_ext = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-7){prod[7]}}, prod};
  assign sum_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];

`ifdef PROD_ACC_SAT_EN
  // The guard bit carries the true sign of the sum, so it picks the rail.
  assign sum_wr = !sum_ovf ? sum_ext[ACC_W-1:0] :
                  (sum_ext[ACC_W] ? ACC_MIN : ACC_MAX);
`else
  assign sum_wr = sum_ext[ACC_W-1:0];
`endif

  // Terminal count: the transfer that consumes the last remaining term.
  assign last_term = (cnt_q == 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = n_terms;
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = (n_terms == 4'd0) ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (in_valid) begin
          acc_d = sum_wr;
          ovf_d = ovf_q | sum_ovf;
          cnt_d = cnt_q - 4'd1;
          if (last_term) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs are pure decodes of the state register, so neither
  // depends combinationally on in_valid or out_ready.
  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign acc       = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_prod_acc.sv
module tb_prod_acc;

  localparam int ACC_W = 10;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic [3:0]              n_terms = 4'd0;
  logic                    in_valid = 1'b0;
  logic [7:0]              prod = 8'd0;
  logic                    in_ready;
  logic signed [ACC_W-1:0] acc;
  logic                    ovf;
  logic                    busy;
  logic                    out_valid;
  logic                    out_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int acc;
    int ovf;
  } res_t;
  res_t exp_q[$];

  prod_acc #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n_terms(n_terms),
    .in_valid(in_valid), .prod(prod), .in_ready(in_ready), .acc(acc),
    .ovf(ovf), .busy(busy), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every result handshake pops the next expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got result acc=%0d, expected none", acc);
      end else begin
        res_t r;
        r = exp_q.pop_front();
        chk("sb_acc", int'(acc), r.acc);
        chk("sb_ovf", int'(ovf), r.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of run");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_n(input int n);
    start   = 1'b1;
    n_terms = 4'(n);
    tick();
    start   = 1'b0;
  endtask

  task automatic xfer(input int v);
    in_valid = 1'b1;
    prod     = 8'(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic release_result;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_release_out_valid", int'(out_valid), 0);
    chk("post_release_busy", int'(busy), 0);
  endtask

  task automatic push(input int a, input int o);
    res_t r;
    r.acc = a;
    r.ovf = o;
    exp_q.push_back(r);
  endtask

  initial begin
    int exp8, exp9;
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_acc", int'(acc), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    rst = 1'b0;
    tick();

    // 6 - 4 + 12 = 14, result on the 4th cycle after start
    push(14, 0);
    start_n(3);
    chk("t1_in_ready", int'(in_ready), 1);
    chk("t1_busy", int'(busy), 1);
    xfer(6);
    xfer(-4);
    chk("t1_early_out_valid", int'(out_valid), 0);
    chk("t1_partial_acc", int'(acc), 2);
    xfer(12);
    chk("t1_out_valid", int'(out_valid), 1);
    chk("t1_in_ready_done", int'(in_ready), 0);
    chk("t1_acc", int'(acc), 14);
    release_result();

    // n_terms = 0 goes straight to DONE
    push(0, 0);
    start_n(0);
    chk("t2_out_valid", int'(out_valid), 1);
    chk("t2_in_ready", int'(in_ready), 0);
    chk("t2_acc", int'(acc), 0);
    release_result();
    chk("t2_in_ready_after", int'(in_ready), 0);

    // in_valid gaps, then a held result
    push(-16, 0);
    start_n(2);
    xfer(-8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_gap_in_ready", int'(in_ready), 1);
      chk("t3_gap_acc", int'(acc), -8);
    end
    xfer(-8);
    chk("t3_out_valid", int'(out_valid), 1);
    chk("t3_acc", int'(acc), -16);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_out_valid", int'(out_valid), 1);
      chk("t3_hold_acc", int'(acc), -16);
    end
    release_result();

    // overflow: nine products of 64
`ifdef PROD_ACC_SAT_EN
    exp8 = 511;
    exp9 = 511;
`else
    exp8 = -512;
    exp9 = -448;
`endif
    push(exp9, 1);
    start_n(9);
    for (int i = 1; i <= 9; i++) begin
      xfer(64);
      if (i == 7) begin
        chk("t4_ovf_7", int'(ovf), 0);
        chk("t4_acc_7", int'(acc), 448);
      end
      if (i == 8) begin
        chk("t4_ovf_8", int'(ovf), 1);
        chk("t4_acc_8", int'(acc), exp8);
      end
    end
    chk("t4_out_valid", int'(out_valid), 1);
    chk("t4_acc", int'(acc), exp9);
    release_result();

    // reset mid-accumulation aborts
    start_n(5);
    xfer(10);
    xfer(20);
    chk("t5_partial_acc", int'(acc), 30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_in_ready", int'(in_ready), 0);
    chk("t5_rst_out_valid", int'(out_valid), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_acc", int'(acc), 0);
    push(-56, 0);
    start_n(1);
    xfer(-56);
    chk("t5_out_valid", int'(out_valid), 1);
    chk("t5_acc", int'(acc), -56);
    release_result();

    // start ignored in ACC and DONE, and on the release edge
    push(6, 0);
    start_n(3);
    xfer(1);
    start    = 1'b1;
    n_terms  = 4'd7;
    in_valid = 1'b1;
    prod     = 8'd2;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    xfer(3);
    chk("t6_out_valid", int'(out_valid), 1);
    chk("t6_acc", int'(acc), 6);
    start   = 1'b1;
    n_terms = 4'd0;
    tick();
    start   = 1'b0;
    chk("t6_done_start_out_valid", int'(out_valid), 1);
    chk("t6_done_start_acc", int'(acc), 6);
    out_ready = 1'b1;
    start     = 1'b1;
    n_terms   = 4'd0;
    tick();
    out_ready = 1'b0;
    chk("t6_release_busy", int'(busy), 0);
    chk("t6_release_out_valid", int'(out_valid), 0);
    chk("t6_release_acc", int'(acc), 6);
    push(0, 0);
    tick();
    start = 1'b0;
    chk("t6_restart_out_valid", int'(out_valid), 1);
    chk("t6_restart_acc", int'(acc), 0);
    release_result();

    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
